// File: rtl/oled_spi_rx.sv
// Receive side of the OLED SPI display link: deserialises SCLK/DATA/DC back into
// command/data bytes and buffers them in a show-ahead FIFO for an on-chip monitor.
module oled_spi_rx #(
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        oled_spi_clk,
    input  logic        oled_spi_data,
    input  logic        oled_dc_n,
    input  logic        oled_reset_n,
    output logic [7:0]  rx_data,
    output logic        rx_dc,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_overflow,
    output logic        rx_frame_err,
    output logic [15:0] byte_count
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE     = (AW + 1)'(1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic [SYNC_STAGES-1:0] dc_sync_r;
    logic [SYNC_STAGES-1:0] rstn_sync_r;

    logic        sclk_dly_r;
    logic        rise_r;
    logic        bit_r;
    logic        dc_r;

    state_t      state_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [15:0] timer_r;
    logic        frame_err_r;

    logic [8:0]  mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [7:0]  rx_data_r;
    logic        rx_dc_r;
    logic        rx_valid_r;
    logic        overflow_r;
    logic [15:0] byte_count_r;

    logic        hold_s;
    logic        full_s;
    logic        pop_s;
    logic        push_req_s;
    logic        push_ok_s;
    logic [8:0]  new_entry_s;
    logic [8:0]  head_s;
    logic [AW:0] rd_next_s;
    logic [AW:0] wr_next_s;

    // Identical synchroniser chains keep SCLK, DATA, DC and RESET_N mutually aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            data_sync_r <= {SYNC_STAGES{1'b0}};
            dc_sync_r   <= {SYNC_STAGES{1'b0}};
            rstn_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], oled_spi_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], oled_spi_data};
            dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], oled_dc_n};
            rstn_sync_r <= {rstn_sync_r[SYNC_STAGES-2:0], oled_reset_n};
        end
    end

    // Registered rising-edge strobe with the data/DC bits that belong to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_dly_r <= 1'b0;
            rise_r     <= 1'b0;
            bit_r      <= 1'b0;
            dc_r       <= 1'b0;
        end else begin
            sclk_dly_r <= sclk_sync_r[SYNC_STAGES-1];
            rise_r     <= sclk_sync_r[SYNC_STAGES-1] & ~sclk_dly_r;
            bit_r      <= data_sync_r[SYNC_STAGES-1];
            dc_r       <= dc_sync_r[SYNC_STAGES-1];
        end
    end

    // Push/pop decisions and the next FIFO head (write-through when the push lands on an empty queue).
    always_comb begin
        hold_s      = ~rstn_sync_r[SYNC_STAGES-1];
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s       = rx_valid_r && rx_ready;
        new_entry_s = {dc_r, shift_r[6:0], bit_r};
        if (!hold_s && (state_r == ST_SHIFT) && rise_r && (bit_cnt_r == 3'd7)) begin
            push_req_s = 1'b1;
        end else begin
            push_req_s = 1'b0;
        end
        push_ok_s = push_req_s && (!full_s || pop_s);
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (push_ok_s) begin
            wr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_next_s = wr_ptr_r;
        end
        if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
            head_s = new_entry_s;
        end else begin
            head_s = mem_r[rd_next_s[AW-1:0]];
        end
    end

    // FIFO storage; contents are only ever read after being written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= new_entry_s;
        end
    end

    // FIFO pointers, registered head/valid, sticky overflow and the byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= {(AW + 1){1'b0}};
            rd_ptr_r     <= {(AW + 1){1'b0}};
            rx_data_r    <= 8'h00;
            rx_dc_r      <= 1'b0;
            rx_valid_r   <= 1'b0;
            overflow_r   <= 1'b0;
            byte_count_r <= 16'h0000;
        end else if (hold_s) begin
            wr_ptr_r   <= {(AW + 1){1'b0}};
            rd_ptr_r   <= {(AW + 1){1'b0}};
            rx_valid_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_next_s;
            rd_ptr_r   <= rd_next_s;
            rx_valid_r <= (wr_next_s != rd_next_s);
            if (wr_next_s != rd_next_s) begin
                rx_dc_r   <= head_s[8];
                rx_data_r <= head_s[7:0];
            end
            if (push_req_s && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
            if (push_ok_s) begin
                byte_count_r <= byte_count_r + 16'd1;
            end
        end
    end

    // Receiver FSM and idle timer; a display reset (HOLD) overrides any edge in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            timer_r     <= 16'h0000;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (rise_r) begin
                timer_r <= 16'h0000;
            end else if (timer_r != 16'hFFFF) begin
                timer_r <= timer_r + 16'd1;
            end
            if (hold_s) begin
                state_r   <= ST_HOLD;
                bit_cnt_r <= 3'd0;
                shift_r   <= 8'h00;
            end else begin
                case (state_r)
                    ST_HOLD: begin
                        state_r <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (rise_r) begin
                            shift_r   <= {shift_r[6:0], bit_r};
                            bit_cnt_r <= 3'd1;
                            state_r   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (rise_r) begin
                            shift_r <= {shift_r[6:0], bit_r};
                            if (bit_cnt_r == 3'd7) begin
                                bit_cnt_r <= 3'd0;
                                state_r   <= ST_IDLE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else if (timer_r == TIMEOUT_VAL) begin
                            frame_err_r <= 1'b1;
                            bit_cnt_r   <= 3'd0;
                            shift_r     <= 8'h00;
                            state_r     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_dc        = rx_dc_r;
    assign rx_valid     = rx_valid_r;
    assign rx_overflow  = overflow_r;
    assign rx_frame_err = frame_err_r;
    assign byte_count   = byte_count_r;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx: drives SPI bytes at clk/8 and checks the
// received stream against a queue-based reference of what was sent.
module tb_oled_spi_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        sdata;
    logic        dc_n;
    logic        reset_n;
    logic        ready_cmd;
    logic        rand_ready;
    logic        rand_en;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_dc;
    logic        rx_valid;
    logic        rx_overflow;
    logic        rx_frame_err;
    logic [15:0] byte_count;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int ferr_cyc = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    assign rx_ready = rand_en ? rand_ready : ready_cmd;

    oled_spi_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .IDLE_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .oled_spi_clk(sclk), .oled_spi_data(sdata), .oled_dc_n(dc_n), .oled_reset_n(reset_n),
        .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) rand_ready = 1'($urandom_range(0, 1));

    // A consumer handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst && rx_valid && rx_ready) got_q.push_back({rx_dc, rx_data});
        if (!rst && rx_frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; sclk = 1'b0; sdata = 1'b0; dc_n = 1'b0; reset_n = 1'b1;
        ready_cmd = 1'b0; rand_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        got_q.delete(); exp_q.delete(); ferr_cnt = 0;
    endtask

    task automatic send_bit(input logic b, input logic dc);
        sclk = 1'b0; sdata = b; dc_n = dc;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
    endtask

    // Sends bits 7..1, then raises SCLK for bit 0 and returns three clk cycles later.
    task automatic send_to_last_edge(input logic [7:0] b, input logic dc);
        for (int i = 7; i >= 1; i--) send_bit(b[i], dc);
        sclk = 1'b0; sdata = b[0]; dc_n = dc;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] b;
        apply_reset();
        b = 8'($urandom_range(1, 255));
        send_byte(b, 1'b1);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        nvec++;
        if (byte_count !== 16'd1 || rx_valid !== 1'b1 || rx_data !== b) begin
            nerr++; $display("FAIL pre_reset: count=%0d valid=%b data=%h want 1 1 %h", byte_count, rx_valid, rx_data, b);
        end
        rst = 1'b1;
        #1;
        nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL reset_data: got %h want 00", rx_data); end
        nvec++; if (rx_dc !== 1'b0) begin nerr++; $display("FAIL reset_dc: got %b want 0", rx_dc); end
        nvec++; if (rx_overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", rx_overflow); end
        nvec++; if (rx_frame_err !== 1'b0) begin nerr++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
        nvec++; if (byte_count !== 16'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", byte_count); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        ready_cmd = 1'b1;
        exp_q.push_back({1'b0, 8'hAE});
        send_to_last_edge(8'hAE, 1'b0);
        nvec++;
        if (byte_count !== 16'd0 || rx_valid !== 1'b0) begin
            nerr++; $display("FAIL single_early: count=%0d valid=%b want 0 0 before E+3", byte_count, rx_valid);
        end
        @(negedge clk);
        nvec++;
        if (byte_count !== 16'd1 || rx_valid !== 1'b1 || rx_data !== 8'hAE || rx_dc !== 1'b0) begin
            nerr++; $display("FAIL single_latency: count=%0d valid=%b data=%h dc=%b want 1 1 ae 0", byte_count, rx_valid, rx_data, rx_dc);
        end
        repeat (10) @(negedge clk);
        sclk = 1'b0;
        nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL single_num: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL single_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bs [3];
        logic       ds [3];
        bs[0] = 8'h81; bs[1] = 8'h7F; bs[2] = 8'h00;
        ds[0] = 1'b0;  ds[1] = 1'b1;  ds[2] = 1'b1;
        apply_reset();
        ready_cmd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({ds[i], bs[i]});
            send_byte(bs[i], ds[i]);
        end
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        nvec++; if (byte_count !== 16'd3) begin nerr++; $display("FAIL b2b_count: got %0d want 3", byte_count); end
        nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL b2b_num: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1);
            if (i <= 4) exp_q.push_back({1'b1, 8'(i)});
        end
        sclk = 1'b0;
        repeat (5) @(negedge clk);
        nvec++; if (rx_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %b want 1", rx_overflow); end
        nvec++; if (byte_count !== 16'd4) begin nerr++; $display("FAIL ovf_count: got %0d want 4", byte_count); end
        ready_cmd = 1'b1;
        repeat (10) @(negedge clk);
        nvec++; if (rx_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", rx_overflow); end
        nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL ovf_num: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++; if (rx_overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", rx_overflow); end
    endtask

    task automatic test_timeout();
        int t0;
        apply_reset();
        ready_cmd = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        sclk = 1'b0;
        t0 = cyc;
        repeat (300) @(negedge clk);
        nvec++; if (ferr_cnt != 1) begin nerr++; $display("FAIL tmo_pulses: got %0d want 1", ferr_cnt); end
        nvec++;
        if ((ferr_cyc - t0) < 250 || (ferr_cyc - t0) > 260) begin
            nerr++; $display("FAIL tmo_when: got cycle %0d of gap want 250..260", ferr_cyc - t0);
        end
        exp_q.push_back({1'b1, 8'hA5});
        send_byte(8'hA5, 1'b1);
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        nvec++; if (byte_count !== 16'd1) begin nerr++; $display("FAIL tmo_count: got %0d want 1", byte_count); end
        nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL tmo_num: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL tmo_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_display_reset();
        logic [7:0] b;
        apply_reset();
        send_byte(8'($urandom()), 1'b1);
        send_byte(8'($urandom()), 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
        reset_n = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL dreset_valid: got %b want 0", rx_valid); end
        nvec++; if (byte_count !== 16'd2) begin nerr++; $display("FAIL dreset_count: got %0d want 2", byte_count); end
        ready_cmd = 1'b1;
        b = 8'($urandom());
        exp_q.push_back({1'b0, b});
        send_byte(b, 1'b0);
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        nvec++; if (byte_count !== 16'd3) begin nerr++; $display("FAIL dreset_after: got %0d want 3", byte_count); end
        nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL dreset_num: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL dreset_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_simultaneous();
        logic [7:0] b;
        logic       d;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom()); d = 1'($urandom_range(0, 1));
            exp_q.push_back({d, b});
            send_byte(b, d);
        end
        b = 8'($urandom()); d = 1'($urandom_range(0, 1));
        exp_q.push_back({d, b});
        send_to_last_edge(b, d);
        ready_cmd = 1'b1;
        @(negedge clk);
        ready_cmd = 1'b0;
        #2;
        nvec++; if (rx_overflow !== 1'b0) begin nerr++; $display("FAIL full_ovf: got %b want 0", rx_overflow); end
        nvec++; if (byte_count !== 16'd5) begin nerr++; $display("FAIL full_count: got %0d want 5", byte_count); end
        nvec++;
        if (rx_valid !== 1'b1 || {rx_dc, rx_data} !== exp_q[1]) begin
            nerr++; $display("FAIL full_head: valid=%b head=%h want 1 %h", rx_valid, {rx_dc, rx_data}, exp_q[1]);
        end
        @(negedge clk);
        ready_cmd = 1'b1;
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL full_num: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL full_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       d;
        apply_reset();
        rand_en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom()); d = 1'($urandom_range(0, 1));
            exp_q.push_back({d, b});
            send_byte(b, d);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (20) @(negedge clk);
        rand_en = 1'b0;
        ready_cmd = 1'b1;
        repeat (10) @(negedge clk);
        nvec++; if (byte_count !== 16'd12) begin nerr++; $display("FAIL rand_count: got %0d want 12", byte_count); end
        nvec++; if (rx_overflow !== 1'b0) begin nerr++; $display("FAIL rand_ovf: got %b want 0", rx_overflow); end
        nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL rand_num: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rand_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; sdata = 1'b0; dc_n = 1'b0; reset_n = 1'b1;
        ready_cmd = 1'b0; rand_en = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_display_reset();
        test_full_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/oled_spi_rx.md
# oled_spi_rx

- Receive-side counterpart of the OLED SPI display link. It deserialises the `oled_spi_clk`/`oled_spi_data` stream, with `oled_dc_n` and `oled_reset_n`, back into command/data bytes.
- Bytes are buffered in a small FIFO with a valid/ready output.
- It sits beside the game/OLED top as an on-chip loopback monitor, so display traffic can be checked in hardware and in simulation.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of 2, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops on every serial input; ≥2.
- `IDLE_TIMEOUT`, 255: `clk` cycles without an SCLK rising edge before a partial byte is discarded; 1..65535.
- `clk`  in  1  system clock; must be ≥4× the SCLK frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `oled_spi_clk`  in  1  serial clock; idle low; data sampled on rising edge (mode 0).
- `oled_spi_data`  in  1  serial data, MSB first.
- `oled_dc_n`  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- `oled_reset_n`  in  1  display reset, active low; flushes the receiver.
- `rx_data`  out  8  FIFO head byte.
- `rx_dc`  out  1  FIFO head DC flag.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head when `rx_valid && rx_ready`.
- `rx_overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `rx_frame_err`  out  1  one-cycle pulse: a partial byte was discarded by timeout.
- `byte_count`  out  16  count of bytes written into the FIFO; wraps 0xFFFF→0.

## Operation
- Synchronisation:
  - All four serial inputs pass through identical `SYNC_STAGES` flop chains, so they stay mutually aligned.
  - An SCLK rising edge is detected when synced SCLK = 1 and its one-cycle-delayed copy = 0.
- Receiver FSM, three states:
  - HOLD: entered while synced `oled_reset_n` = 0. Bit counter, shift register and FIFO pointers are cleared. SCLK edges are ignored. `rx_overflow` and `byte_count` are untouched. Exits to IDLE when `oled_reset_n` = 1.
  - IDLE: bit counter = 0. An SCLK edge shifts in synced data and goes to SHIFT with counter = 1.
  - SHIFT: each SCLK edge shifts left with the new bit as LSB and increments the counter. On the 8th edge:
    - the byte and the synced `oled_dc_n` are pushed into the FIFO;
    - `byte_count` increments;
    - the counter returns to 0 (IDLE).
  - Back-to-back bytes need no gap.
- Idle timer:
  - Cleared on every SCLK edge; otherwise increments, saturating.
  - In SHIFT, when it reaches `IDLE_TIMEOUT`: the partial byte is discarded, `rx_frame_err` pulses for one cycle, and the FSM returns to IDLE.
  - In IDLE the timer has no effect.
- FIFO (show-ahead):
  - `rx_data`/`rx_dc` show the head whenever `rx_valid` = 1; both are don't-care when `rx_valid` = 0.
  - Pop on `rx_valid && rx_ready`.
  - Push while full without a same-cycle pop: the byte is dropped, `rx_overflow` is set, and `byte_count` does not increment.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: the push happens; `rx_valid` rises next cycle.
- Reset: `rst` clears everything, including `rx_overflow` and `byte_count`. Only `rst` clears `rx_overflow`.

## Timing
- Reset values:
  - `rx_data` = 0x00, `rx_dc` = 0, `rx_valid` = 0, `rx_overflow` = 0, `rx_frame_err` = 0, `byte_count` = 0.
  - FSM in IDLE; idle timer = 0.
- Latency: if raw SCLK's 8th rising edge is first captured by sync stage 1 at clk edge E:
  - the FIFO write and `byte_count` update occur at edge E+`SYNC_STAGES`+1;
  - `rx_valid` is high after that same edge when the FIFO was empty.
- `rx_frame_err` is high for the single cycle after the timer reaches `IDLE_TIMEOUT`.
- `oled_reset_n` takes effect `SYNC_STAGES` cycles after its falling edge.
  - A byte whose 8th edge is detected in the same cycle as the HOLD entry is discarded (HOLD wins).
- `rst` asserted mid-byte or mid-stream: all outputs reach their reset values immediately (asynchronous). The partial byte is lost.
- Data, DC and SCLK must be stable for ≥2 `clk` cycles around each SCLK rising edge.

## Test plan
- Single command: send 0xAE with DC = 0 at SCLK = clk/8, `rx_ready` = 1.
  - Expect exactly one `rx_valid` cycle with `rx_data` = 0xAE and `rx_dc` = 0.
  - Expect `byte_count` = 1.
  - Expect the FIFO write at E+3 after the 8th edge (`SYNC_STAGES` = 2).
- Back-to-back: 0x81 (DC = 0), 0x7F, 0x00 (DC = 1) with no gaps, `rx_ready` = 1.
  - Expect the bytes in order with DC flags 0, 1, 1 and `byte_count` = 3.
- Overflow: `rx_ready` = 0; send 5 bytes 0x01..0x05 (`FIFO_DEPTH` = 4).
  - Expect `rx_overflow` = 1 and `byte_count` = 4.
  - Raise `rx_ready`: expect 0x01..0x04 out, and `rx_overflow` still 1.
  - Expect `rx_overflow` = 0 only after `rst`.
- Timeout: 3 bits, then SCLK idle for 300 cycles, then a full byte 0xA5.
  - Expect one `rx_frame_err` pulse around cycle 255 of the idle gap.
  - Expect 0xA5 to be received correctly, and `byte_count` to increase by 1 only.
- Display reset: 2 bytes queued with `rx_ready` = 0; pulse `oled_reset_n` low for 10 cycles mid-way through a third byte.
  - Expect `rx_valid` = 0 and `byte_count` still 2.
  - Expect the next full byte to be received cleanly.
- Full-FIFO simultaneity: FIFO full, `rx_ready` = 1 in the same cycle as a new push.
  - Expect no overflow, the head popped, the new byte appended, and `byte_count` incremented.
